// File: rtl/pc_sequencer.sv
// Program-counter sequencer: one fetch per cycle, one-bubble taken branches via an
// external label->target table, call/return through a small internal LIFO.
module pc_sequencer #(
  parameter int PC_W        = 12,
  parameter int LBL_W       = 8,
  parameter int START_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             br_req,
  input  logic             br_taken,
  input  logic [LBL_W-1:0] br_label,
  input  logic             call,
  input  logic             ret,
  output logic [LBL_W-1:0] lut_label,
  input  logic [PC_W-1:0]  lut_next_pc,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             done,
  output logic             err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PC_W-1:0] START = PC_W'(START_PC);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, TGT, DONE} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [LBL_W-1:0]   lbl_q, lbl_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [PC_W-1:0]    stack_q [2**IDX_W];
  logic               push_en;
  logic [IDX_W-1:0]   push_idx, pop_idx;
  logic [PC_W-1:0]    pc_inc;

  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = push_idx - IDX_W'(1);
  assign pc_inc   = pc_q + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lbl_d   = lbl_q;
    sp_d    = sp_q;
    vld_d   = vld_q;
    done_d  = done_q;
    err_d   = err_q;
    push_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = START;
          state_d = RUN;
          vld_d   = 1'b1;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end else if (ret) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - SP_W'(1);
          end
        end else if (br_req && call) begin
          if (sp_q == SP_FULL) begin
            err_d   = 1'b1;
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            lbl_d   = br_label;
            state_d = TGT;
            vld_d   = 1'b0;
          end
        end else if (br_req && br_taken) begin
          lbl_d   = br_label;
          state_d = TGT;
          vld_d   = 1'b0;
        end else begin
          pc_d = pc_inc;
        end
      end
      TGT: begin
        // Table is addressed by the registered label, so its output is stable here.
        pc_d    = lut_next_pc;
        state_d = RUN;
        vld_d   = 1'b1;
      end
      DONE: begin
        if (start) begin
          pc_d    = START;
          sp_d    = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          state_d = RUN;
          vld_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START;
      lbl_q   <= '0;
      sp_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lbl_q   <= lbl_d;
      sp_q    <= sp_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage holds data only; validity is tracked by sp_q.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign pc        = pc_q;
  assign lut_label = lbl_q;
  assign pc_valid  = vld_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter controller that sequences instruction fetch and drives the branch-target lookup table (8-bit label -> 12-bit target).
- Sits between the decoder/control unit and instruction memory: issues one fetch address per cycle and inserts a one-cycle bubble on taken branches while the table resolves the target.
- Supports unconditional call/return through a small internal return-address stack.
- Handles start/halt handshaking with the testbench.

Parameters:
- PC_W, 12, program-counter width; must equal the table output width.
- LBL_W, 8, branch-label width; must equal the table input width.
- START_PC, 0, PC loaded on start.
- STACK_DEPTH, 4, return-stack entries (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse; begins execution from IDLE or DONE.
- halt  input  1  current instruction is a halt.
- br_req  input  1  current instruction is a branch or call.
- br_taken  input  1  branch condition is true; ignored when call=1.
- br_label  input  LBL_W  label of the branch/call target.
- call  input  1  with br_req=1: unconditional call, push return address.
- ret  input  1  current instruction is a return.
- lut_label  output  LBL_W  registered label driven to the table.
- lut_next_pc  input  PC_W  combinational table output for lut_label.
- pc  output  PC_W  current fetch address.
- pc_valid  output  1  pc is a live fetch this cycle; control inputs are sampled only when high.
- done  output  1  program halted, level.
- err  output  1  sticky return-stack overflow/underflow.

Behaviour:
- Reset (asynchronous, immediate, also mid-branch):
  - state=IDLE, pc=START_PC, lut_label=0, pc_valid=0, done=0, err=0, stack pointer=0.
- States: IDLE, RUN, TGT, DONE.
- IDLE:
  - pc_valid=0. All inputs except start are ignored.
  - start -> pc<=START_PC, go to RUN.
- RUN:
  - pc_valid=1. Inputs are evaluated with the following priority, one action per cycle:
    1. halt -> DONE; done=1 next cycle; pc holds.
    2. ret:
       - Stack empty: err<=1, go to DONE.
       - Otherwise: pc<=top entry, pop. Stays in RUN with no bubble.
    3. br_req & call:
       - Stack full: err<=1, go to DONE.
       - Otherwise: push (pc+1) mod 2^PC_W, lut_label<=br_label, go to TGT.
    4. br_req & br_taken -> lut_label<=br_label, go to TGT.
    5. Otherwise (including a not-taken branch) -> pc<=(pc+1) mod 2^PC_W. 4095 wraps to 0.
- TGT:
  - pc_valid=0 (one bubble); inputs are ignored.
  - pc<=lut_next_pc (sampled from the table addressed by the registered lut_label), go to RUN.
  - Taken-branch latency: request cycle -> 1 bubble -> target fetched in cycle 3.
  - An unmapped label yields the table default target of 0; no error is raised.
- DONE:
  - done=1, pc_valid=0; pc and err hold.
  - start -> pc<=START_PC, stack pointer<=0, err<=0, done<=0, go to RUN.
- start is ignored in RUN and TGT.
- lut_label changes only on entry to TGT; otherwise it holds its last value.
- Stack:
  - LIFO of STACK_DEPTH entries, each PC_W wide.
  - Full when the pointer equals STACK_DEPTH; empty when it equals 0.
  - A push and a pop never occur in the same cycle, by priority.
- Simultaneous asserts within one RUN cycle follow the priority above:
  - halt with br_req -> halt wins.
  - ret with call -> ret wins; no push occurs.

Test Plan:
- Reset, start at START_PC=0, no control inputs for 5 cycles -> pc 0,1,2,3,4, pc_valid=1 every cycle, done=0.
- At pc=5, br_req=1, br_taken=1, br_label=2, table returns 352 -> lut_label=2 next cycle, pc_valid=0 for one cycle, then pc=352 with pc_valid=1.
- At pc=10, br_req=1, br_taken=0, label=18 -> pc=11 next cycle, no bubble, lut_label unchanged.
- Call at pc=20 with label 18 (target 8), then ret at pc=9 -> pc sequence 20, bubble, 8, 9, 21.
- With STACK_DEPTH=4: five nested calls without returns -> fifth call sets err=1, done=1, pc_valid=0. A separate run: ret with empty stack -> err=1, done=1.
- Halt at pc=7 -> done=1 from the next cycle, pc holds at 7; pulse start -> pc=0, done=0, err=0. Separately: assert reset during a TGT bubble -> all outputs return to reset values immediately, state IDLE.
